// File: rtl/netflow_flow_cache.sv
// netflow_flow_cache: direct-mapped NetFlow V7 flow table fed by the tuple
// parser. Each cycle runs either a PKT op (tuple present) or a SWEEP op
// through a 3-stage pipeline (register, RAM read, update); completed flows
// leave through a first-word-fall-through export FIFO that drops on overflow.
module netflow_flow_cache #(
    parameter int          TABLE_DEPTH_LOG2 = 10,
    parameter logic [63:0] IDLE_TIMEOUT_NS  = 64'd15_000_000_000,
    parameter int          EXP_FIFO_DEPTH   = 16,
    parameter int          PKT_CNT_W        = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tuple_valid,
    input  logic [127:0]         src_ip,
    input  logic [127:0]         dst_ip,
    input  logic [15:0]          src_port,
    input  logic [15:0]          dst_port,
    input  logic [7:0]           l4_proto,
    input  logic [7:0]           ip_tos,
    input  logic [7:0]           tcp_flags,
    input  logic [63:0]          hw_ts_ns,
    output logic                 exp_valid,
    input  logic                 exp_ready,
    output logic [295:0]         exp_key,
    output logic [7:0]           exp_tos,
    output logic [7:0]           exp_flags,
    output logic [PKT_CNT_W-1:0] exp_pkts,
    output logic [63:0]          exp_first_ts,
    output logic [63:0]          exp_last_ts,
    output logic [1:0]           exp_reason,
    output logic [31:0]          drop_cnt
);

    localparam int IW    = TABLE_DEPTH_LOG2;
    localparam int DEPTH = 1 << IW;
    localparam int KEY_W = 296;
    localparam int PAD_W = ((KEY_W + IW - 1) / IW) * IW;
    localparam int FAW   = $clog2(EXP_FIFO_DEPTH);
    localparam int CW    = FAW + 1;

    localparam logic [1:0] REASON_IDLE      = 2'd0;
    localparam logic [1:0] REASON_TCP_END   = 2'd1;
    localparam logic [1:0] REASON_COLLISION = 2'd2;

    typedef enum logic [1:0] {OP_NONE, OP_PKT, OP_SWEEP} op_e;

    typedef struct packed {
        logic [KEY_W-1:0]     key;
        logic [7:0]           tos;
        logic [7:0]           flags;
        logic [PKT_CNT_W-1:0] pkts;
        logic [63:0]          first_ts;
        logic [63:0]          last_ts;
    } entry_t;

    typedef struct packed {
        entry_t     ent;
        logic [1:0] reason;
    } rec_t;

    typedef struct packed {
        op_e              op;
        logic [IW-1:0]    idx;
        logic [KEY_W-1:0] key;
        logic [7:0]       tos;
        logic [7:0]       flags;
        logic [63:0]      ts;
    } stage_t;

    // Index bit i folds every key bit whose position is congruent to i mod IW.
    function automatic logic [IW-1:0] hash_idx(input logic [KEY_W-1:0] k);
        logic [PAD_W-1:0] kp;
        logic [IW-1:0]    h;
        kp = PAD_W'(k);
        h  = '0;
        for (int c = 0; c < PAD_W / IW; c++) h ^= kp[c*IW +: IW];
        return h;
    endfunction

    logic [KEY_W-1:0] key_in;
    stage_t           op_in, s0, s1, s2;
    logic [IW-1:0]    sweep_ptr;
    logic [63:0]      now_ts;
    logic [DEPTH-1:0] valid_q;
    entry_t           ram [DEPTH];
    entry_t           rd_data, fwd_data, cur_ent, upd;
    logic             fwd_hit, cur_valid, ram_we, valid_we, valid_next;
    logic [63:0]      age;
    logic             req_a, req_b;
    rec_t             rec_a, rec_b, first_rec;
    rec_t             fifo_mem [EXP_FIFO_DEPTH];
    logic [FAW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]    count, free;
    logic             pop, ok0, ok1;
    logic [1:0]       n_req, n_push, n_drop;
    logic [32:0]      drop_sum;

    assign key_in = {src_ip, dst_ip, src_port, dst_port, l4_proto};

    // Choose this cycle's op: tuples always win, idle cycles sweep the table.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        op_in = '0;
        if (tuple_valid) begin
            op_in.op    = OP_PKT;
            op_in.idx   = hash_idx(key_in);
            op_in.key   = key_in;
            op_in.tos   = ip_tos;
            op_in.flags = tcp_flags;
            op_in.ts    = hw_ts_ns;
        end else begin
            op_in.op  = OP_SWEEP;
            op_in.idx = sweep_ptr;
        end
    end

    // Pipeline stage registers, sweep pointer and monotonic current time.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (rst) begin
            s0        <= '0;
            s1        <= '0;
            s2        <= '0;
            sweep_ptr <= '0;
            now_ts    <= '0;
        end else begin
            s0 <= op_in;
            s1 <= s0;
            s2 <= s1;
            if (!tuple_valid) sweep_ptr <= sweep_ptr + IW'(1);
            if (tuple_valid && hw_ts_ns > now_ts) now_ts <= hw_ts_ns;
        end
    end

    // Entry RAM: one write from S2, one synchronous read issued from S1.
    always_ff @(posedge clk) begin
        // NOTE: RAM contents are not reset; the valid flops decide what is live.
        if (ram_we) ram[s2.idx] <= upd;
        rd_data  <= ram[s1.idx];
        fwd_data <= upd;
    end

    // Capture the write that lands on the same edge as the read it would race.
    always_ff @(posedge clk) begin
        if (rst) fwd_hit <= 1'b0;
        else     fwd_hit <= ram_we && (s2.idx == s1.idx);
    end

    // Valid bits live in flops so reset can clear the whole table at once.
    always_ff @(posedge clk) begin
        if (rst)           valid_q <= '0;
        else if (valid_we) valid_q[s2.idx] <= valid_next;
    end

    // S2 update: merge/install/collide for PKT ops, age-out for SWEEP ops.
    always_comb begin
        cur_ent   = fwd_hit ? fwd_data : rd_data;
        cur_valid = valid_q[s2.idx];
        age       = (now_ts > cur_ent.last_ts) ? now_ts - cur_ent.last_ts : 64'd0;
        upd.key      = s2.key;
        upd.tos      = s2.tos;
        upd.flags    = s2.flags;
        upd.pkts     = PKT_CNT_W'(1);
        upd.first_ts = s2.ts;
        upd.last_ts  = s2.ts;
        ram_we     = 1'b0;
        valid_we   = 1'b0;
        valid_next = 1'b0;
        req_a      = 1'b0;
        req_b      = 1'b0;
        rec_a      = '{ent: cur_ent, reason: REASON_COLLISION};
        rec_b      = '{ent: cur_ent, reason: REASON_IDLE};
        case (s2.op)
            OP_PKT: begin
                if (cur_valid && cur_ent.key == s2.key) begin
                    upd.tos      = cur_ent.tos;
                    upd.first_ts = cur_ent.first_ts;
                    upd.flags    = cur_ent.flags | s2.flags;
                    upd.pkts     = (&cur_ent.pkts) ? cur_ent.pkts
                                                   : cur_ent.pkts + PKT_CNT_W'(1);
                end else if (cur_valid) begin
                    req_a = 1'b1;
                end
                ram_we     = 1'b1;
                valid_we   = 1'b1;
                valid_next = 1'b1;
                if (s2.key[7:0] == 8'd6 && (upd.flags & 8'h05) != 8'h00) begin
                    req_b      = 1'b1;
                    rec_b      = '{ent: upd, reason: REASON_TCP_END};
                    valid_next = 1'b0;
                end
            end
            OP_SWEEP: begin
                if (cur_valid && age > IDLE_TIMEOUT_NS) begin
                    req_b    = 1'b1;
                    valid_we = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // FIFO admission: up to two pushes, each checked against remaining space.
    always_comb begin
        pop       = exp_valid && exp_ready;
        free      = CW'(EXP_FIFO_DEPTH) - count + CW'(pop);
        n_req     = {1'b0, req_a} + {1'b0, req_b};
        first_rec = req_a ? rec_a : rec_b;
        ok0       = (n_req != 2'd0) && (free >= CW'(1));
        ok1       = (n_req == 2'd2) && (free >= CW'(2));
        n_push    = {1'b0, ok0} + {1'b0, ok1};
        n_drop    = n_req - n_push;
        drop_sum  = {1'b0, drop_cnt} + 33'(n_drop);
    end

    // FIFO storage; occupancy is tracked separately so this needs no reset.
    always_ff @(posedge clk) begin
        if (ok0) fifo_mem[wr_ptr] <= first_rec;
        if (ok1) fifo_mem[wr_ptr + FAW'(1)] <= rec_b;
    end

    // FIFO pointers, occupancy and the saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else begin
            wr_ptr   <= wr_ptr + FAW'(n_push);
            rd_ptr   <= rd_ptr + FAW'(pop);
            count    <= count + CW'(n_push) - CW'(pop);
            drop_cnt <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
        end
    end

    assign exp_valid    = (count != '0);
    assign exp_key      = fifo_mem[rd_ptr].ent.key;
    assign exp_tos      = fifo_mem[rd_ptr].ent.tos;
    assign exp_flags    = fifo_mem[rd_ptr].ent.flags;
    assign exp_pkts     = fifo_mem[rd_ptr].ent.pkts;
    assign exp_first_ts = fifo_mem[rd_ptr].ent.first_ts;
    assign exp_last_ts  = fifo_mem[rd_ptr].ent.last_ts;
    assign exp_reason   = fifo_mem[rd_ptr].reason;

endmodule
